// File: rtl/fetch_pkg.sv
// Shared definitions for the flash instruction-fetch path.
//  - fetch_state_e       : controller FSM encodings
//  - RESET_ADDR_DEFAULT  : default first fetch address after reset
//  - FETCH_STRIDE        : byte increment between consecutive fetch words
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam int unsigned FETCH_STRIDE       = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {address, data} pairs between the flash and the IR.
// Ports:
//  clk, rst      clock, asynchronous active-high reset (clears the FIFO)
//  flush         synchronous clear, wins over push/pop in the same cycle
//  push, din     write an entry (ignored when full unless popping too)
//  pop           remove the head entry (ignored when empty)
//  head          current head entry
//  count         number of occupied entries
//  empty, full   occupancy flags
module fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    // A push into a full FIFO is only safe if the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy tracking with flush priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/flash_fetch_ctrl.sv
// Flash-side instruction-fetch controller.
// Issues word reads to flash (flash_rd/flash_addr/flash_ack/flash_rdata),
// buffers words in a prefetch FIFO and hands them to the IR with a one-cycle
// ld_ir strobe (dout_flash/ir_pc stable from the strobe until the next load).
// A branch strobe flushes the FIFO and redirects fetching to branch_addr.
// Ports:
//  clk, rst      clock, asynchronous active-high reset
//  fetch_en      permits new flash requests
//  branch        1-cycle redirect strobe, branch_addr is the target
//  ir_ready      IR can accept a word
//  flash_*       flash read handshake
//  dout_flash    word presented to the IR, ir_pc its address
//  ld_ir         IR load strobe
//  fifo_count    occupied prefetch entries
module flash_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        DEPTH      = 2,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(RESET_ADDR_DEFAULT),
    localparam int unsigned       CW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              ir_ready,
    output logic              flash_rd,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_ack,
    input  logic [DATA_W-1:0] flash_rdata,
    output logic [DATA_W-1:0] dout_flash,
    output logic              ld_ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [CW-1:0]     fifo_count
);

    fetch_state_e              state_r;
    fetch_state_e              state_nx_s;
    logic [ADDR_W-1:0]         fetch_addr_r;
    logic [ADDR_W-1:0]         fetch_addr_nx_s;
    logic [ADDR_W-1:0]         req_addr_r;
    logic [ADDR_W-1:0]         req_addr_nx_s;
    logic                      flash_rd_r;
    logic                      ld_ir_r;
    logic [DATA_W-1:0]         dout_r;
    logic [ADDR_W-1:0]         ir_pc_r;
    logic                      push_s;
    logic                      pop_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;
    logic [CW-1:0]             fifo_count_s;
    logic [ADDR_W+DATA_W-1:0]  head_s;
    logic [ADDR_W-1:0]         branch_tgt_s;
    logic [ADDR_W-1:0]         next_addr_s;
    logic                      space_after_push_s;

    assign branch_tgt_s = {branch_addr[ADDR_W-1:2], 2'b00};
    assign next_addr_s  = fetch_addr_r + ADDR_W'(FETCH_STRIDE);
    // ld_ir is never high two cycles running, and a branch cycle issues no load.
    assign pop_s        = !fifo_empty_s && ir_ready && !ld_ir_r && !branch;
    // A push is only ever made when not full, so a simultaneous pop always leaves room.
    assign space_after_push_s = pop_s || (fifo_count_s < CW'(DEPTH - 1));

    assign flash_rd   = flash_rd_r;
    assign flash_addr = req_addr_r;
    assign ld_ir      = ld_ir_r;
    assign dout_flash = dout_r;
    assign ir_pc      = ir_pc_r;
    assign fifo_count = fifo_count_s;

    // Fetch FSM next-state, redirect and push decisions.
    always_comb begin
        state_nx_s      = state_r;
        fetch_addr_nx_s = fetch_addr_r;
        req_addr_nx_s   = req_addr_r;
        push_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A redirect in IDLE only retargets; the next request goes to the new address.
                if (branch) begin
                    fetch_addr_nx_s = branch_tgt_s;
                end else if (fetch_en && !fifo_full_s) begin
                    state_nx_s    = ST_REQ;
                    req_addr_nx_s = fetch_addr_r;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (branch) begin
                    fetch_addr_nx_s = branch_tgt_s;
                    if (flash_ack) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DISCARD;
                    end
                end else if (flash_ack) begin
                    push_s          = 1'b1;
                    fetch_addr_nx_s = next_addr_s;
                    if (fetch_en && space_after_push_s) begin
                        req_addr_nx_s = next_addr_s;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // The stale request keeps its address on the bus until the flash answers.
                if (branch) begin
                    fetch_addr_nx_s = branch_tgt_s;
                end else begin
                    fetch_addr_nx_s = fetch_addr_r;
                end
                if (flash_ack) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DISCARD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch pointer and registered flash request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fetch_addr_r <= RESET_ADDR;
            req_addr_r   <= {ADDR_W{1'b0}};
            flash_rd_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            fetch_addr_r <= fetch_addr_nx_s;
            req_addr_r   <= req_addr_nx_s;
            flash_rd_r   <= (state_nx_s != ST_IDLE);
        end
    end

    // IR load pulse and presented word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ir_r <= 1'b0;
            dout_r  <= {DATA_W{1'b0}};
            ir_pc_r <= {ADDR_W{1'b0}};
        end else begin
            ld_ir_r <= pop_s;
            if (pop_s) begin
                dout_r  <= head_s[DATA_W-1:0];
                ir_pc_r <= head_s[ADDR_W+DATA_W-1:DATA_W];
            end else begin
                dout_r  <= dout_r;
                ir_pc_r <= ir_pc_r;
            end
        end
    end

    fetch_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch),
        .push  (push_s),
        .din   ({fetch_addr_r, flash_rdata}),
        .pop   (pop_s),
        .head  (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

endmodule
